// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Holds the FSM state encoding, port indices and byte-select codes.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam logic [1:0] BS_BYTE = 2'b00;
  localparam logic [1:0] BS_HALF = 2'b01;
  localparam logic [1:0] BS_WORD = 2'b10;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester ports 0/1 plus the data_mem bus.
// slave = arbiter side, master = requesters and memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              p0_req;
  logic              p0_we;
  logic [1:0]        p0_bs;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [1:0]        p1_bs;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [1:0]        mem_bs;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_bs, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_bs, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output mem_en, mem_we, mem_bs, mem_addr, mem_wdata
  );

  modport master (
    output p0_req, p0_we, p0_bs, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_bs, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  mem_en, mem_we, mem_bs, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: winner selection for the two requesters.
// DMEM_ARB_RR_EN: round-robin with last-winner pointer; else port 0 wins ties.
// Ports: win (selected port), req0/req1; with the macro also clk, rst, take.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  output logic win,
  input  logic req0,
  input  logic req1
`ifdef DMEM_ARB_RR_EN
  ,
  input  logic clk,
  input  logic rst,
  input  logic take
`endif
);

`ifdef DMEM_ARB_RR_EN
  // last winner; resets to port 1 so port 0 takes the first tie
  logic last;

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT_DBG;
    end else if (take) begin
      last <= win;
    end
  end

  always_comb begin
    win = PORT_CPU;
    unique case (1'b1)
      req0 && req1:  win = ~last;
      req1 && !req0: win = PORT_DBG;
      default:       win = PORT_CPU;
    endcase
  end
`else
  always_comb begin
    win = (req1 && !req0) ? PORT_DBG : PORT_CPU;
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port data_mem between CPU (p0) and debug (p1).
// Ports: clk, rst (sync, high), bus (dmem_arbiter_if.slave), busy, gnt_id.
// DMEM_ARB_RR_EN selects round-robin tie-break instead of fixed priority.
// mem_rdata is sampled on the edge entering RESP.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic          busy,
  output logic          gnt_id
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              any;
  logic              win;
  logic              to_resp;
  logic              sel_we;
  logic [1:0]        sel_bs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign any = bus.p0_req | bus.p1_req;

  // last cycle before RESP: ISSUE when latency is 1, else final WAIT
  assign to_resp =
    (state == ISSUE && LAT_M1 == 4'd0) ||
    (state == WAIT && cnt == 4'd1);

`ifdef DMEM_ARB_RR_EN
  logic take;
  assign take = (state == IDLE) && any;

  dmem_arb_pick u_pick (
    .win  (win),
    .req0 (bus.p0_req),
    .req1 (bus.p1_req),
    .clk  (clk),
    .rst  (rst),
    .take (take)
  );
`else
  dmem_arb_pick u_pick (
    .win  (win),
    .req0 (bus.p0_req),
    .req1 (bus.p1_req)
  );
`endif

  assign sel_we    = win ? bus.p1_we    : bus.p0_we;
  assign sel_bs    = win ? bus.p1_bs    : bus.p0_bs;
  assign sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      gnt_id        <= PORT_CPU;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_bs    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            state         <= ISSUE;
            busy          <= 1'b1;
            gnt_id        <= win;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= sel_we;
            bus.mem_bs    <= sel_bs;
            bus.mem_addr  <= sel_addr;
            bus.mem_wdata <= sel_wdata;
          end
        end
        ISSUE: begin
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
          cnt        <= LAT_M1;
          state      <= to_resp ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (to_resp) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.p0_ack   <= 1'b0;
      bus.p1_ack   <= 1'b0;
      bus.p0_rdata <= '0;
      bus.p1_rdata <= '0;
    end else begin
      bus.p0_ack <= to_resp && gnt_id == PORT_CPU;
      bus.p1_ack <= to_resp && gnt_id == PORT_DBG;
      if (to_resp && gnt_id == PORT_CPU) begin
        bus.p0_rdata <= bus.mem_rdata;
      end
      if (to_resp && gnt_id == PORT_DBG) begin
        bus.p1_rdata <= bus.mem_rdata;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data_mem between the CPU load/store path (port 0) and the debug/loader port (port 1).
- Sits between the cpu datapath and data_mem.
- Serialises one access at a time through a small FSM with a memory-latency counter.
- Returns a one-cycle ack with read data to the winning requester.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory side.
- DATA_W, 32, data width.
- MEM_LAT, 1, data_mem read latency in cycles after the issue cycle; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  CPU request; held with stable fields until p0_ack.
- p0_we  in  1  CPU write enable.
- p0_bs  in  2  CPU byte select: 00 byte, 01 half, 10 word.
- p0_addr  in  ADDR_W  CPU address.
- p0_wdata  in  DATA_W  CPU write data.
- p0_ack  out  1  one-cycle completion pulse.
- p0_rdata  out  DATA_W  read data, valid when p0_ack is high.
- p1_req, p1_we, p1_bs, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for the debug port.
- mem_en  out  1  data_mem enable.
- mem_we  out  1  data_mem write enable.
- mem_bs  out  2  data_mem byte select.
- mem_addr  out  ADDR_W  data_mem address.
- mem_wdata  out  DATA_W  data_mem write data.
- mem_rdata  in  DATA_W  data_mem read data.
- busy  out  1  high in any state other than IDLE.
- gnt_id  out  1  index of the currently or last granted port.

Behaviour:
- Reset values (sync rst high at a clock edge): state=IDLE; all acks, mem_en, mem_we and busy = 0; mem_bs=00; mem_addr, mem_wdata, p0_rdata, p1_rdata = 0; gnt_id=0; RR pointer=1, so port 0 wins first.
- Reset mid-transaction: FSM returns to IDLE and no ack is issued. A memory write already issued is not undone.
- States and transitions:
  - IDLE: if any req is high, select a winner, latch its we/bs/addr/wdata and gnt_id, go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): mem_en=1; mem_we/mem_bs/mem_addr/mem_wdata come from the latched request. Load counter with MEM_LAT-1. Go to WAIT if MEM_LAT>1, else to RESP.
  - WAIT: mem_en=0; decrement counter; go to RESP when counter reaches 0.
  - RESP (1 cycle): capture mem_rdata into the winner's rdata register on entry. Assert the winner's ack for exactly this cycle. Go to IDLE.
- Latency: a req first seen in IDLE at cycle N gives mem_en in cycle N+1 and ack in cycle N+1+MEM_LAT. For MEM_LAT=1, ack is at N+2.
- Throughput: one access per MEM_LAT+2 cycles.
- Request fields are latched in IDLE. Changes to addr/wdata after the grant are ignored.
- Write ack: the write is committed at the ISSUE edge. Read data is also captured for writes and is don't-care.
- req dropped before ack: the transaction still completes and ack is still pulsed.
- req still high in the cycle after ack: treated as a new request and re-arbitrated in IDLE.
- p*_rdata of the non-winning port holds its last value. Each rdata holds until that port's next ack.
- Both ports requesting in IDLE: resolved by the arbitration policy, see Optional Feature.
- Only the winner is granted. The loser waits with req held.
- At most one ack is high in any cycle.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin. A 1-bit pointer records the last winner. On a tie, the port other than the last winner wins. A single requester always wins. The pointer updates in IDLE on grant.
- Undefined: fixed priority, port 0 always wins a tie. Port 1 can starve under continuous CPU traffic, and this is accepted. The pointer register is not built.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding: IDLE, ISSUE, WAIT, RESP;
  - port index constants: PORT_CPU=0, PORT_DBG=1;
  - byte-select constants: BS_BYTE, BS_HALF, BS_WORD.
- One sub-module, dmem_arb_pick: winner selection plus the round-robin pointer register, gated by DMEM_ARB_RR_EN.
- FSM, latency counter and data steering stay in dmem_arbiter.

Test Plan:
- Single read, MEM_LAT=1: p0_req with addr=0x10, memory word=0xDEADBEEF → mem_en at N+1 with mem_addr=0x10, p0_ack at N+2 with p0_rdata=0xDEADBEEF, p1_ack stays 0.
- Write then read, MEM_LAT=3: p1 writes 0x12345678 to 0x20 with bs=10, then reads 0x20 → each ack 4 cycles after issue start, read returns 0x12345678.
- Simultaneous reqs, macro undefined: both held high for 3 transactions → all grants go to port 0, gnt_id=0, p1_ack never asserted.
- Simultaneous reqs with DMEM_ARB_RR_EN: both held high → grants alternate 0,1,0,1, with exactly one ack per RESP cycle.
- Reset mid-operation: assert rst in WAIT with MEM_LAT=3 → next cycle state IDLE, busy=0, no ack; a held req is then re-served normally.
- Early req drop: p0_req high for 1 cycle only → p0_ack still pulses at N+1+MEM_LAT, then arbiter idles with busy=0.
